// File: rtl/mad_min_search.sv
// Raster-order minimum-SAD search over a SEARCH_W x SEARCH_H candidate window.
// Reports the first (raster-earliest) minimum and its (x, y) position with a one-cycle done pulse.
module mad_min_search #(
  parameter int SEARCH_W = 8,
  parameter int SEARCH_H = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mad_valid,
  input  logic [11:0] mad,
  output logic        busy,
  output logic        done,
  output logic [11:0] best_mad,
  output logic [3:0]  best_x,
  output logic [3:0]  best_y
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0]  X_LAST  = 4'(SEARCH_W - 1);
  localparam logic [3:0]  Y_LAST  = 4'(SEARCH_H - 1);
  localparam logic [11:0] MAD_MAX = 12'hFFF;

  state_t      state;
  state_t      state_next;

  logic [3:0]  x;
  logic [3:0]  y;
  logic [11:0] run_min;
  logic [3:0]  run_x;
  logic [3:0]  run_y;

  logic        consume;
  logic        take;
  logic        last;
  logic        first;
  logic [11:0] final_mad;
  logic [3:0]  final_x;
  logic [3:0]  final_y;

  // The (0,0) candidate is always taken so that a window of all 12'hFFF still reports (0,0).
  always_comb begin
    consume   = (state == SCAN) && mad_valid;
    first     = (x == 4'd0) && (y == 4'd0);
    take      = consume && (first || (mad < run_min));
    last      = consume && (x == X_LAST) && (y == Y_LAST);
    final_mad = take ? mad : run_min;
    final_x   = take ? x : run_x;
    final_y   = take ? y : run_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The final comparison is folded into the published result on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x        <= 4'd0;
      y        <= 4'd0;
      run_min  <= MAD_MAX;
      run_x    <= 4'd0;
      run_y    <= 4'd0;
      best_mad <= MAD_MAX;
      best_x   <= 4'd0;
      best_y   <= 4'd0;
    end else if ((state == IDLE) && start) begin
      x       <= 4'd0;
      y       <= 4'd0;
      run_min <= MAD_MAX;
      run_x   <= 4'd0;
      run_y   <= 4'd0;
    end else if (consume) begin
      if (take) begin
        run_min <= mad;
        run_x   <= x;
        run_y   <= y;
      end
      if (x == X_LAST) begin
        x <= 4'd0;
        y <= y + 4'd1;
      end else begin
        x <= x + 4'd1;
      end
      if (last) begin
        best_mad <= final_mad;
        best_x   <= final_x;
        best_y   <= final_y;
      end
    end
  end

endmodule
